muldiv_sched: RTL and testbench

Execute-stage controller for the multi-cycle multiplier and divider. It accepts one mul/div-class op per EX occupancy, latches the operands and drives the start/sign handshake to the selected unit. It generates the EX stall, holds the result while downstream stages are stalled, and issues exactly one HI/LO write or one GPR result per instruction. It sits between the EX-stage decode (alucontrol) and the mul, div and hilo instances.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_result_fmt.sv | 32 +++
 rtl/muldiv_sched.sv | 134 +++++++++++++
 tb/tb_muldiv_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the EX-stage mul/div scheduler.
// The MUL_ACCUM_EN macro is consumed by muldiv_sched and muldiv_result_fmt.
package muldiv_pkg;

  localparam int HILO_W = 64;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MUL   = 4'd5,
    MADD  = 4'd6,
    MADDU = 4'd7,
    MSUB  = 4'd8,
    MSUBU = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_signed(muldiv_op_t o);
    return o inside {MULT, DIV, MADD, MSUB, MUL};
  endfunction

  function automatic logic is_div(muldiv_op_t o);
    return o inside {DIV, DIVU};
  endfunction

  function automatic logic is_accum(muldiv_op_t o);
    return o inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_result_fmt.sv
// Formats the captured unit result into HI/LO write data and the MUL GPR word.
// With MUL_ACCUM_EN defined, MADD*/MSUB* fold in the current HI/LO value;
// otherwise no accumulate adder is built and the result passes straight through.
module muldiv_result_fmt
  import muldiv_pkg::*;
(
  input  muldiv_op_t        op,
  input  logic [HILO_W-1:0] res,
  input  logic [HILO_W-1:0] hilo_cur,
  output logic [HILO_W-1:0] hilo_wdata,
  output logic [31:0]       gpr_result
);

  assign gpr_result = res[31:0];

`ifdef MUL_ACCUM_EN
  // Accumulate ops combine the live HI/LO with the product, wrapping at 64 bits.
  always_comb begin
    hilo_wdata = res;
    case (op)
      MADD, MADDU: hilo_wdata = hilo_cur + res;
      MSUB, MSUBU: hilo_wdata = hilo_cur - res;
      default:     hilo_wdata = res;
    endcase
  end
`else
  logic unused_fmt_in;
  assign unused_fmt_in = ^{hilo_cur, op};
  assign hilo_wdata    = res;
`endif

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage controller for the multi-cycle multiplier/divider: accepts one op,
// drives the unit handshake, stalls EX, and issues exactly one HI/LO or GPR write.
// Optional feature macro: MUL_ACCUM_EN (enables MADD/MADDU/MSUB/MSUBU).
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  muldiv_op_t        op,
  input  logic [31:0]       src_a,
  input  logic [31:0]       src_b,
  input  logic [HILO_W-1:0] hilo_cur,
  input  logic              stallE,
  input  logic              flushE,
  input  logic              flush_exceptionM,
  input  logic              mul_ready,
  input  logic [HILO_W-1:0] mul_result,
  input  logic              div_ready,
  input  logic [HILO_W-1:0] div_result,
  output logic              mul_start,
  output logic              div_start,
  output logic              unit_sign,
  output logic [31:0]       unit_a,
  output logic [31:0]       unit_b,
  output logic              md_stall,
  output logic              hilo_we,
  output logic [HILO_W-1:0] hilo_wdata,
  output logic              gpr_valid,
  output logic [31:0]       gpr_result,
  output logic              timeout_err
);

  state_t            state_q, state_d;
  muldiv_op_t        op_q;
  logic              sign_q, nowr_q;
  logic [31:0]       a_q, b_q;
  logic [HILO_W-1:0] res_q;
  logic [CNT_W-1:0]  cnt_q;

  logic op_ok, accept, div_zero, sel_div, sel_ready, cnt_last, do_write;

`ifdef MUL_ACCUM_EN
  assign op_ok = (op != NONE);
`else
  assign op_ok = (op != NONE) && !is_accum(op);
`endif

  assign accept    = (state_q == IDLE) && op_valid && op_ok && !flushE;
  assign div_zero  = is_div(op) && (src_b == '0);
  assign sel_div   = is_div(op_q);
  assign sel_ready = sel_div ? div_ready : mul_ready;
  assign cnt_last  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // Write only on the cycle DONE is released, unless squashed or div-by-zero.
  assign do_write  = (state_q == DONE) && !stallE && !flushE && !flush_exceptionM && !nowr_q;

  // Next state plus the handshake/stall/abort strobes.
  always_comb begin
    state_d     = state_q;
    md_stall    = 1'b0;
    mul_start   = 1'b0;
    div_start   = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          md_stall = 1'b1;
          state_d  = div_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        md_stall  = 1'b1;
        mul_start = !sel_div;
        div_start = sel_div;
        if (flushE)         state_d = IDLE;
        else if (sel_ready) state_d = DONE;
        else if (cnt_last) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end
      end
      DONE: begin
        if (flushE || !stallE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, watchdog counter and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= NONE;
      sign_q  <= 1'b0;
      nowr_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op;
        a_q    <= src_a;
        b_q    <= src_b;
        sign_q <= is_signed(op);
        nowr_q <= div_zero;
        cnt_q  <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == BUSY && sel_ready && !flushE)
        res_q <= sel_div ? div_result : mul_result;
    end
  end

  assign unit_sign = sign_q;
  assign unit_a    = a_q;
  assign unit_b    = b_q;
  assign hilo_we   = do_write && (op_q != MUL);
  assign gpr_valid = do_write && (op_q == MUL);

  muldiv_result_fmt u_fmt (
    .op         (op_q),
    .res        (res_q),
    .hilo_cur   (hilo_cur),
    .hilo_wdata (hilo_wdata),
    .gpr_result (gpr_result)
  );

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: behavioural mul/div unit models, directed
// corner cases and randomized ops; a monitor checks every write/abort strobe.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  muldiv_op_t  op;
  logic [31:0] src_a, src_b;
  logic [63:0] hilo_cur;
  logic        stallE, flushE, flush_exceptionM;
  logic        mul_ready, div_ready;
  logic [63:0] mul_result, div_result;
  logic        mul_start, div_start, unit_sign, md_stall, hilo_we, gpr_valid, timeout_err;
  logic [31:0] unit_a, unit_b, gpr_result;
  logic [63:0] hilo_wdata;

  typedef struct { int kind; logic [63:0] data; } exp_t;  // kind 0 hilo, 1 gpr, 2 timeout
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sched #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
    .hilo_cur(hilo_cur), .stallE(stallE), .flushE(flushE), .flush_exceptionM(flush_exceptionM),
    .mul_ready(mul_ready), .mul_result(mul_result), .div_ready(div_ready), .div_result(div_result),
    .mul_start(mul_start), .div_start(div_start), .unit_sign(unit_sign), .unit_a(unit_a),
    .unit_b(unit_b), .md_stall(md_stall), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .gpr_valid(gpr_valid), .gpr_result(gpr_result), .timeout_err(timeout_err)
  );

  function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b, logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] divmod(logic [31:0] a, logic [31:0] b, logic s);
    logic signed [63:0] ea, eb, q, r;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    if (eb == 0) return 64'd0;
    q = ea / eb;
    r = ea % eb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] ref_val(muldiv_op_t o, logic [31:0] a, logic [31:0] b, logic [63:0] hc);
    logic s;
    logic [63:0] p;
    s = o inside {MULT, DIV, MADD, MSUB, MUL};
    p = prod(a, b, s);
    case (o)
      DIV, DIVU:   return divmod(a, b, s);
      MADD, MADDU: return hc + p;
      MSUB, MSUBU: return hc - p;
      MUL:         return {32'b0, p[31:0]};
      default:     return p;
    endcase
  endfunction

  // Unit models: ready after a programmable number of start cycles.
  int   mul_lat = 4, div_lat = 6, mcnt = 0, dcnt = 0;
  logic div_never = 1'b0, div_extra = 1'b0;
  always @(posedge clk) begin
    mcnt <= mul_start ? mcnt + 1 : 0;
    dcnt <= div_start ? dcnt + 1 : 0;
  end
  always_comb begin
    mul_ready  = mul_start && (mcnt == mul_lat - 1);
    div_ready  = (div_start && !div_never && (dcnt == div_lat - 1)) || div_extra;
    mul_result = prod(unit_a, unit_b, unit_sign);
    div_result = divmod(unit_a, unit_b, unit_sign);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_evt(input int k, input logic [63:0] v);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %h expected no event", k, v);
    end else begin
      e = sb.pop_front();
      chk("evt_kind", 64'(k), 64'(e.kind));
      chk("evt_data", v, e.data);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (hilo_we)     check_evt(0, hilo_wdata);
      if (gpr_valid)   check_evt(1, {32'b0, gpr_result});
      if (timeout_err) check_evt(2, 64'd0);
    end
  end

  task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hc, input int hold, input logic fexc,
                       input logic ovr, input logic [63:0] oval);
    logic acc, dz, isd, tmo;
    int lat, exp_stall, exp_ms, exp_ds, stc, ms, ds;
    acc = (o != NONE);
`ifndef MUL_ACCUM_EN
    if (o inside {MADD, MADDU, MSUB, MSUBU}) acc = 1'b0;
`endif
    isd = o inside {DIV, DIVU};
    dz  = isd && (b == 0);
    tmo = acc && isd && !dz && div_never;
    lat = tmo ? TO : (isd ? div_lat : mul_lat);
    exp_stall = !acc ? 0 : (dz ? 1 : 1 + lat);
    exp_ms = (acc && !dz && !isd) ? lat : 0;
    exp_ds = (acc && !dz && isd) ? lat : 0;
    if (tmo) sb.push_back('{2, 64'd0});
    else if (acc && !dz && !fexc)
      sb.push_back('{(o == MUL) ? 1 : 0, ovr ? oval : ref_val(o, a, b, hc)});

    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b; hilo_cur = hc;
    stallE = (hold > 0); flush_exceptionM = fexc;
    @(negedge clk);
    stc = md_stall ? 1 : 0;
    ms = 0; ds = 0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = NONE; src_a = $urandom; src_b = $urandom;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ms += int'(mul_start);
      ds += int'(div_start);
      if (!md_stall) break;
      stc++;
      @(posedge clk); #1;
    end
    chk("stall_cycles", 64'(stc), 64'(exp_stall));
    chk("mul_start_cycles", 64'(ms), 64'(exp_ms));
    chk("div_start_cycles", 64'(ds), 64'(exp_ds));
    for (int h = 0; h < hold; h++) begin
      chk("held_no_write", {61'b0, hilo_we, gpr_valid, md_stall}, 64'd0);
      @(posedge clk); #1;
      if (h == hold - 1) stallE = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    flush_exceptionM = 1'b0;
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    muldiv_op_t ops [10];
    ops = '{NONE, MULT, MULTU, DIV, DIVU, MUL, MADD, MADDU, MSUB, MSUBU};
    rst = 1'b0; op_valid = 1'b0; op = NONE; src_a = '0; src_b = '0; hilo_cur = '0;
    stallE = 1'b0; flushE = 1'b0; flush_exceptionM = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {57'b0, md_stall, hilo_we, gpr_valid, mul_start, div_start, timeout_err, unit_sign}, 64'd0);
    chk("reset_operands", {unit_a, unit_b}, 64'd0);
    chk("reset_wdata", hilo_wdata, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    mul_lat = 4;
    do_op(MULT, 32'hFFFFFFFE, 32'd3, 64'd0, 0, 1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFA);
    div_lat = 6;
    do_op(DIVU, 32'd100, 32'd7, 64'd0, 3, 1'b0, 1'b1, 64'h00000002_0000000E);
    do_op(DIV, 32'd55, 32'd0, 64'd0, 0, 1'b0, 1'b0, 64'd0);
    mul_lat = 3;
    do_op(MADD, 32'd1, 32'd1, 64'h00000000_FFFFFFFF, 0, 1'b0, 1'b1, 64'h00000001_00000000);
    do_op(MUL, 32'd12345, 32'hFFFFFFF0, 64'd0, 1, 1'b0, 1'b0, 64'd0);
    do_op(MUL, 32'd77, 32'd3, 64'd0, 0, 1'b1, 1'b0, 64'd0);

    // Flush two cycles into a divide; a stray ready afterwards must be ignored.
    div_lat = 8;
    @(posedge clk); #1 op_valid = 1'b1; op = DIV; src_a = 32'hFFFFFF9C; src_b = 32'd7;
    @(posedge clk); #1 op_valid = 1'b0; op = NONE;
    @(posedge clk); #1 flushE = 1'b1;
    @(negedge clk); chk("flush_cycle_div_start", {63'b0, div_start}, 64'd1);
    @(posedge clk); #1 flushE = 1'b0;
    @(negedge clk); chk("after_flush_idle", {62'b0, div_start, md_stall}, 64'd0);
    @(posedge clk); #1 div_extra = 1'b1;
    @(negedge clk); chk("late_ready_ignored", {62'b0, hilo_we, md_stall}, 64'd0);
    @(posedge clk); #1 div_extra = 1'b0;
    mul_lat = 2;
    do_op(MULTU, 32'hDEADBEEF, 32'h12345678, 64'd0, 0, 1'b0, 1'b0, 64'd0);

    // Divider that never answers trips the watchdog.
    div_never = 1'b1;
    do_op(DIVU, 32'd50, 32'd3, 64'd0, 0, 1'b0, 1'b0, 64'd0);
    div_never = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    mul_lat = 10;
    @(posedge clk); #1 op_valid = 1'b1; op = MULT; src_a = 32'd5; src_b = 32'd7;
    @(posedge clk); #1 op_valid = 1'b0; op = NONE;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("rst_mid_op", {62'b0, md_stall, mul_start}, 64'd0);
    chk("rst_mid_operands", {unit_a, unit_b}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int n = 0; n < 40; n++) begin
      muldiv_op_t ro;
      logic [31:0] ra, rb;
      ro = ops[$urandom_range(0, 9)];
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      mul_lat = $urandom_range(1, 6);
      div_lat = $urandom_range(1, 12);
      do_op(ro, ra, rb, {$urandom, $urandom}, $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0), 1'b0, 64'd0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_drain", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
